// File: rtl/lcd_cmd_seq.sv
// Command sequencer feeding lcd_ctrl: walks a command ROM, issues each command when
// lcd_ctrl is idle, and streams the full image ROM after every LOAD (code 0) command.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | command ROM read in flight
// WAIT  | holding until lcd_ctrl drops busy
// ISSUE | cmd_valid strobe
// LOAD  | streaming image bytes on datain
// GUARD | let lcd_ctrl's busy rise before the next fetch
// FIN   | done pulse, back to IDLE
module lcd_cmd_seq #(
    parameter int IMG_N  = 108,
    parameter int CMD_N  = 22,
    parameter int IMG_AW = 7,
    parameter int CMD_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [CMD_AW-1:0] cmd_addr,
    input  logic [2:0]        cmd_rdata,
    output logic [IMG_AW-1:0] img_addr,
    input  logic [7:0]        img_rdata,
    output logic [2:0]        cmd,
    output logic              cmd_valid,
    output logic [7:0]        datain,
    input  logic              busy,
    output logic              seq_busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_LOAD,
        S_GUARD,
        S_FIN
    } state_t;

    localparam logic [CMD_AW-1:0] CMD_LAST = CMD_AW'(CMD_N - 1);
    localparam logic [IMG_AW-1:0] IMG_LAST = IMG_AW'(IMG_N - 1);

    state_t            state_q, state_d;
    logic [CMD_AW-1:0] cmd_addr_q, cmd_addr_d;
    logic [IMG_AW-1:0] img_addr_q, img_addr_d;
    logic [IMG_AW-1:0] ld_cnt_q, ld_cnt_d;
    logic [2:0]        cmd_q, cmd_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cmd_addr_q <= '0;
            img_addr_q <= '0;
            ld_cnt_q   <= '0;
            cmd_q      <= '0;
        end else begin
            state_q    <= state_d;
            cmd_addr_q <= cmd_addr_d;
            img_addr_q <= img_addr_d;
            ld_cnt_q   <= ld_cnt_d;
            cmd_q      <= cmd_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_addr_d = cmd_addr_q;
        img_addr_d = img_addr_q;
        ld_cnt_d   = ld_cnt_q;
        cmd_d      = cmd_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cmd_addr_d = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                // ROM data for the new address is settled by now and stays put while we stall
                if (!busy) begin
                    cmd_d   = cmd_rdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_q == 3'd0) begin
                    img_addr_d = img_addr_q + 1'b1;
                    ld_cnt_d   = IMG_LAST;
                    state_d    = S_LOAD;
                end else begin
                    state_d = S_GUARD;
                end
            end
            S_LOAD: begin
                // Address runs one ahead of datain to hide the image ROM latency
                if (ld_cnt_q == '0) begin
                    img_addr_d = '0;
                    state_d    = S_GUARD;
                end else begin
                    img_addr_d = img_addr_q + 1'b1;
                    ld_cnt_d   = ld_cnt_q - 1'b1;
                end
            end
            S_GUARD: begin
                cmd_addr_d = cmd_addr_q + 1'b1;
                state_d    = (cmd_addr_q == CMD_LAST) ? S_FIN : S_FETCH;
            end
            S_FIN: begin
                cmd_addr_d = '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_addr  = cmd_addr_q;
    assign img_addr  = img_addr_q;
    assign cmd       = cmd_q;
    assign cmd_valid = (state_q == S_ISSUE);
    assign datain    = (state_q == S_LOAD) ? img_rdata : 8'd0;
    assign seq_busy  = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done      = (state_q == S_FIN);

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Scoreboard bench for lcd_cmd_seq: random ROMs and busy behaviour, expected event stream
// built from the command list, checked by an independent monitor.
module tb_lcd_cmd_seq;
    localparam int IMG_N  = 108;
    localparam int CMD_N  = 22;
    localparam int IMG_AW = 7;
    localparam int CMD_AW = 5;
    localparam int K_CMD  = 0;
    localparam int K_BYTE = 1;
    localparam int K_DONE = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              busy = 1'b0;
    logic [CMD_AW-1:0] cmd_addr;
    logic [2:0]        cmd_rdata = 3'd0;
    logic [IMG_AW-1:0] img_addr;
    logic [7:0]        img_rdata = 8'd0;
    logic [2:0]        cmd;
    logic              cmd_valid;
    logic [7:0]        datain;
    logic              seq_busy;
    logic              done;

    lcd_cmd_seq #(.IMG_N(IMG_N), .CMD_N(CMD_N), .IMG_AW(IMG_AW), .CMD_AW(CMD_AW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cmd_addr(cmd_addr), .cmd_rdata(cmd_rdata),
        .img_addr(img_addr), .img_rdata(img_rdata),
        .cmd(cmd), .cmd_valid(cmd_valid), .datain(datain),
        .busy(busy), .seq_busy(seq_busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [2:0] rom_cmd [2**CMD_AW];
    logic [7:0] rom_img [2**IMG_AW];

    // synchronous ROMs: data for an address appears the cycle after it is presented
    always @(posedge clk) begin
        cmd_rdata <= rom_cmd[cmd_addr];
        img_rdata <= rom_img[img_addr];
    end

    typedef struct {
        int         kind;
        logic [7:0] val;
    } exp_t;
    exp_t expq[$];

    int n_tests = 0;
    int n_fail = 0;
    int vcnt = 0;
    int done_cnt = 0;
    int cyc = 0;
    int win = 0;
    int last_byte_cyc = 0;
    int done_cyc = 0;
    int busy_max = 0;
    int busy_cnt = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // lcd_ctrl stand-in: raises busy the cycle after each strobe for a random hold
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            busy     = 1'b0;
            busy_cnt = 0;
        end else begin
            busy = (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
            if (cmd_valid) busy_cnt = $urandom_range(busy_max, 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!reset) begin
            win = 0;
        end else begin
            if (win > 0) begin
                chk("valid_during_load", int'(cmd_valid), 0);
                if (expq.size() == 0) chk("byte_unexpected", 1, 0);
                else begin
                    e = expq.pop_front();
                    chk("byte_kind", e.kind, K_BYTE);
                    chk("datain", int'(datain), int'(e.val));
                end
                win--;
                if (win == 0) last_byte_cyc = cyc;
            end else begin
                chk("datain_idle", int'(datain), 0);
                if (cmd_valid) begin
                    vcnt++;
                    chk("issue_while_busy", int'(busy), 0);
                    if (expq.size() == 0) chk("cmd_unexpected", 1, 0);
                    else begin
                        e = expq.pop_front();
                        chk("cmd_kind", e.kind, K_CMD);
                        chk("cmd", int'(cmd), int'(e.val));
                        if (e.kind == K_CMD && e.val == 8'd0) win = IMG_N;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (expq.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    e = expq.pop_front();
                    chk("done_kind", e.kind, K_DONE);
                end
            end
        end
    end

    task automatic fill(input bit first0, input bit last0);
        for (int i = 0; i < 2**CMD_AW; i++) rom_cmd[i] = 3'($urandom_range(7, 0));
        rom_cmd[5] = 3'd0;
        if (first0) rom_cmd[0] = 3'd0;
        if (last0) rom_cmd[CMD_N-1] = 3'd0;
        for (int i = 0; i < 2**IMG_AW; i++) rom_img[i] = 8'($urandom_range(255, 0));
    endtask

    task automatic push_seq();
        exp_t e;
        for (int i = 0; i < CMD_N; i++) begin
            e.kind = K_CMD; e.val = {5'd0, rom_cmd[i]};
            expq.push_back(e);
            if (rom_cmd[i] == 3'd0)
                for (int k = 0; k < IMG_N; k++) begin
                    e.kind = K_BYTE; e.val = rom_img[k];
                    expq.push_back(e);
                end
        end
        e.kind = K_DONE; e.val = 8'd0;
        expq.push_back(e);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("done_timeout", int'(done_cnt != d0), 1);
        repeat (4) @(posedge clk);
        #1;
        chk("done_once", done_cnt - d0, 1);
        chk("queue_empty", expq.size(), 0);
        chk("seq_busy_after_done", int'(seq_busy), 0);
    endtask

    task automatic check_reset_vals();
        chk("rst_cmd", int'(cmd), 0);
        chk("rst_cmd_valid", int'(cmd_valid), 0);
        chk("rst_datain", int'(datain), 0);
        chk("rst_cmd_addr", int'(cmd_addr), 0);
        chk("rst_img_addr", int'(img_addr), 0);
        chk("rst_seq_busy", int'(seq_busy), 0);
        chk("rst_done", int'(done), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        fill(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        reset = 1'b1;

        // random busy holds, stray start mid-sequence must be ignored
        fill(1'b0, 1'b0);
        busy_max = 6;
        vcnt = 0;
        push_seq();
        pulse_start();
        repeat (40) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(20000);
        chk("cmd_valid_count", vcnt, CMD_N);

        // busy never asserted: fixed latency and done spacing
        fill(1'b1, 1'b1);
        busy_max = 0;
        vcnt = 0;
        push_seq();
        pulse_start();
        chk("seq_busy_after_start", int'(seq_busy), 1);
        @(posedge clk); #1;
        chk("latency_cyc2_no_valid", int'(cmd_valid), 0);
        @(posedge clk); #1;
        chk("latency_cyc3_valid", int'(cmd_valid), 1);
        wait_done(20000);
        chk("done_after_last_byte", done_cyc - last_byte_cyc, 2);
        chk("cmd_valid_count_b", vcnt, CMD_N);

        // reset dropped while byte 50 is on datain, then full replay
        fill(1'b1, 1'b0);
        busy_max = 3;
        push_seq();
        pulse_start();
        n = 0;
        while (!cmd_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("first_issue_seen", int'(cmd_valid), 1);
        repeat (51) @(posedge clk);
        #1;
        chk("byte50_before_reset", int'(datain), int'(rom_img[50]));
        #1 reset = 1'b0;
        #1;
        check_reset_vals();
        expq.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        vcnt = 0;
        push_seq();
        pulse_start();
        wait_done(20000);
        chk("cmd_valid_count_replay", vcnt, CMD_N);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
